// File: rtl/od_line_receiver.sv
// Open-drain line receiver: resolves released lines to 1, synchronises, deglitches,
// and emits edge pulses plus sticky fall events. Optional stuck-low detect: OD_STUCK_DETECT_EN.
module od_line_receiver #(
   parameter int unsigned WIDTH         = 6,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 4,
   parameter int unsigned STUCK_CYCLES  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] line_in,
   input  logic [WIDTH-1:0] evt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] evt
`ifdef OD_STUCK_DETECT_EN
   ,
   output logic [WIDTH-1:0] stuck_low
`endif
);

   localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 || STUCK_CYCLES < 1)
   begin : g_param_check
      $error("od_line_receiver: illegal parameter value");
   end

   logic [WIDTH-1:0] res_c;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s_c;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] evt_q, evt_d;

   // Only a hard 0 pulls a line low; z/x mean released and resolve to 1.
   always_comb begin
      res_c = '1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (line_in[i] === 1'b0) res_c[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '1;
      end else begin
         sync_q[0] <= res_c;
         for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s_c = sync_q[SYNC_STAGES-1];

   // Persistence filter: q follows s only after FILTER_CYCLES consecutive mismatches.
   always_comb begin
      q_d = q_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (s_c[i] != q_q[i]) begin
            if (cnt_q[i] == CNT_LAST) q_d[i] = s_c[i];
            else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      rise_d = q_d & ~q_q;
      fall_d = ~q_d & q_q;
      evt_d  = (evt_q & ~evt_clr) | fall_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
         q_q    <= '1;
         rise_q <= '0;
         fall_q <= '0;
         evt_q  <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
         q_q    <= q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         evt_q  <= evt_d;
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign evt  = evt_q;

`ifdef OD_STUCK_DETECT_EN
   localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);

   logic [STK_W-1:0] stk_q [WIDTH];
   logic [STK_W-1:0] stk_d [WIDTH];
   logic [WIDTH-1:0] stuck_q, stuck_d;

   // Saturating count of cycles spent with q low; cleared once q is seen high.
   always_comb begin
      stuck_d = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         stk_d[i] = '0;
         if (!q_q[i]) begin
            stk_d[i]   = (stk_q[i] == STK_MAX) ? stk_q[i] : stk_q[i] + STK_W'(1);
            stuck_d[i] = (stk_d[i] == STK_MAX);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(WIDTH); i++) stk_q[i] <= '0;
         stuck_q <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) stk_q[i] <= stk_d[i];
         stuck_q <= stuck_d;
      end
   end

   assign stuck_low = stuck_q;
`endif

endmodule

// File: tb/tb_od_line_receiver.sv
// Bench for od_line_receiver: directed scenarios plus random line activity checked
// against a persistence/latency reference model.
module tb_od_line_receiver;

   localparam int unsigned W  = 6;
   localparam int unsigned SS = 2;
   localparam int unsigned FC = 4;
   localparam int unsigned SC = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] line_in, evt_clr;
   logic [W-1:0] q, rise, fall, evt;
`ifdef OD_STUCK_DETECT_EN
   logic [W-1:0] stuck_low;
`endif

   always #5 clk = ~clk;

   od_line_receiver #(
      .WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .STUCK_CYCLES(SC)
   ) dut (
      .clk(clk), .rst(rst), .line_in(line_in), .evt_clr(evt_clr),
      .q(q), .rise(rise), .fall(fall), .evt(evt)
`ifdef OD_STUCK_DETECT_EN
      , .stuck_low(stuck_low)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [W-1:0] m_q, m_rise, m_fall, m_evt, m_stuck;
   logic [W-1:0] hist[$];
   int           run[W];
   int           zc[W];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q = '1; m_rise = '0; m_fall = '0; m_evt = '0; m_stuck = '0;
      hist.delete();
      for (int k = 0; k < int'(SS); k++) hist.push_back('1);
      for (int i = 0; i < int'(W); i++) begin run[i] = 0; zc[i] = 0; end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q"},    32'(q),    32'(m_q));
      chk({tag, ".rise"}, 32'(rise), 32'(m_rise));
      chk({tag, ".fall"}, 32'(fall), 32'(m_fall));
      chk({tag, ".evt"},  32'(evt),  32'(m_evt));
`ifdef OD_STUCK_DETECT_EN
      chk({tag, ".stuck"}, 32'(stuck_low), 32'(m_stuck));
`endif
   endtask

   // One clock edge: advance the model with the inputs present at the edge, then compare.
   task automatic step(input string tag);
      logic [W-1:0] s, r, nq;
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         s = hist[0];
         for (int i = 0; i < int'(W); i++) r[i] = (line_in[i] === 1'b0) ? 1'b0 : 1'b1;
         hist.push_back(r);
         void'(hist.pop_front());
         for (int i = 0; i < int'(W); i++) begin
            if (m_q[i] == 1'b0) begin
               if (zc[i] < int'(SC)) zc[i]++;
               m_stuck[i] = (zc[i] >= int'(SC));
            end else begin
               zc[i] = 0;
               m_stuck[i] = 1'b0;
            end
         end
         nq = m_q;
         for (int i = 0; i < int'(W); i++) begin
            if (s[i] != m_q[i]) begin
               run[i]++;
               if (run[i] == int'(FC)) begin nq[i] = s[i]; run[i] = 0; end
            end else begin
               run[i] = 0;
            end
         end
         m_rise = nq & ~m_q;
         m_fall = m_q & ~nq;
         m_q    = nq;
         m_evt  = (m_evt & ~evt_clr) | m_fall;
      end
      #1;
      check_all(tag);
   endtask

   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("rst.q",    32'(q),    32'(6'h3F));
      chk("rst.rise", 32'(rise), 32'(0));
      chk("rst.fall", 32'(fall), 32'(0));
      chk("rst.evt",  32'(evt),  32'(0));
   endtask

   int npulse;

   initial begin
      rst = 1'b0; line_in = '0; evt_clr = '0;
      model_reset();
      #12;
      chk("init.q",   32'(q),   32'(6'h3F));
      chk("init.evt", 32'(evt), 32'(0));

      // Held low through reset: fall on all channels at the 6th edge after release
      for (int k = 0; k < 3; k++) step("t1_inrst");
      chk("t1_inrst.q", 32'(q), 32'(6'h3F));
      rst = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step("t1");
         if (k == 5) chk("t1.fall_early", 32'(fall), 32'(0));
      end
      chk("t1.fall6", 32'(fall), 32'(6'h3F));
      chk("t1.q6",    32'(q),    32'(0));
      chk("t1.evt6",  32'(evt),  32'(6'h3F));

      line_in = '1;
      for (int k = 0; k < 8; k++) step("rel");
      evt_clr = '1; step("clr"); evt_clr = '0;
      chk("clr.evt", 32'(evt), 32'(0));

      // Single line falls: one pulse, q low at 6th edge
      line_in[2] = 1'b0;
      npulse = 0;
      for (int k = 1; k <= 10; k++) begin
         step("t2");
         if (fall[2]) npulse++;
         if (k == 6) chk("t2.q2", 32'(q[2]), 32'(0));
      end
      chk("t2.npulse", 32'(npulse), 32'(1));
      chk("t2.evt2",   32'(evt[2]), 32'(1));

      // Short glitch is absorbed
      line_in[0] = 1'b0;
      for (int k = 0; k < 3; k++) step("t3");
      line_in[0] = 1'b1;
      for (int k = 0; k < 8; k++) step("t3");
      chk("t3.q0", 32'(q[0]), 32'(1));

      // Low then released: one rise
      line_in[5] = 1'b0;
      for (int k = 0; k < 10; k++) step("t4lo");
      line_in[5] = 1'b1;
      npulse = 0;
      for (int k = 0; k < 10; k++) begin step("t4hi"); if (rise[5]) npulse++; end
      chk("t4.nrise", 32'(npulse), 32'(1));
      chk("t4.q5",    32'(q[5]),   32'(1));

      // Clear collides with fall: set wins, next clear succeeds
      line_in = '1;
      for (int k = 0; k < 10; k++) step("settle");
      evt_clr = '1; step("settle_clr"); evt_clr = '0;
      line_in[1] = 1'b0;
      for (int k = 0; k < 5; k++) step("t5");
      evt_clr[1] = 1'b1;
      step("t5.edge6");
      chk("t5.fall1", 32'(fall[1]), 32'(1));
      chk("t5.evt1",  32'(evt[1]),  32'(1));
      step("t5.clr");
      chk("t5.evt1_clr", 32'(evt[1]), 32'(0));
      evt_clr = '0;

      // Reset mid-filter, line held low: fall only after full latency
      line_in = '1;
      for (int k = 0; k < 10; k++) step("settle2");
      line_in[3] = 1'b0;
      for (int k = 0; k < 3; k++) step("t6pre");
      async_reset();
      for (int k = 0; k < 2; k++) step("t6rst");
      rst = 1'b1;
      for (int k = 0; k < 5; k++) step("t6post");
      chk("t6.q3_early", 32'(q[3]), 32'(1));
      step("t6.edge6");
      chk("t6.fall3", 32'(fall[3]), 32'(1));

`ifdef OD_STUCK_DETECT_EN
      line_in = '0;
      for (int k = 0; k < 30; k++) step("stk_lo");
      chk("stk.set", 32'(stuck_low), 32'(6'h3F));
      line_in = '1;
      for (int k = 0; k < 10; k++) step("stk_hi");
      chk("stk.clr", 32'(stuck_low), 32'(0));
`endif

      // Random activity with random clears and occasional resets
      line_in = '1;
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 3) == 0) line_in[$urandom_range(0, W-1)] ^= 1'b1;
         evt_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         if ($urandom_range(0, 399) == 0) begin
            async_reset();
            step("rnd_rst");
            rst = 1'b1;
         end
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
